nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_if.sv | 38 +++
 rtl/nibble_serial_adder_ctrl.sv | 143 ++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// rtl/nibble_serial_adder_ctrl_if.sv - operand/result handshake bundle for nibble_serial_adder_ctrl
// Optional port sub exists only when NIBBLE_SERIAL_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

`ifdef NIBBLE_SERIAL_SUB_EN
  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
  );
  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit adder sequenced through one 4-bit CLA slice
// Optional subtract mode: NIBBLE_SERIAL_SUB_EN.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                        clk,
  input logic                        rst,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int N     = WIDTH / 4;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic               sub_q, sub_d;
`endif

  logic               accept;
  logic               last_nib;
  logic [3:0]         a_nib, b_nib;
  logic [3:0]         g, p, c, s;
  logic               group_gen, group_prop, carry_nxt;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign last_nib = (cnt_q == CNT_W'(N - 1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_nib)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.sum       = sum_q;
    bus.c_out     = c_out_q;
  end

  // Select the active nibble pair; subtract feeds the slice with ~B
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
`ifdef NIBBLE_SERIAL_SUB_EN
    b_nib = b_nib ^ {4{sub_q}};
`endif
  end

  // 4-bit carry-lookahead slice with group generate/propagate
  always_comb begin
    g    = a_nib & b_nib;
    p    = a_nib ^ b_nib;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & carry_q);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    s    = p ^ c;
    group_gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    group_prop = &p;
    carry_nxt  = group_gen | (group_prop & carry_q);
  end

  // Datapath next state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub_d   = sub_q;
`endif
    if (accept) begin
      a_d   = bus.a;
      b_d   = bus.b;
      cnt_d = '0;
`ifdef NIBBLE_SERIAL_SUB_EN
      sub_d   = bus.sub;
      carry_d = bus.sub ? 1'b1 : bus.c_in;
`else
      carry_d = bus.c_in;
`endif
    end else if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (cnt_q == CNT_W'(i)) sum_d[4*i +: 4] = s;
      end
      carry_d = carry_nxt;
      if (last_nib) c_out_d = carry_nxt;
      else          cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
`ifdef NIBBLE_SERIAL_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed self-checking bench for nibble_serial_adder_ctrl
module tb_nibble_serial_adder_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   t1, t2;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic tsub);
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    check("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.a = ta; bus.b = tb_; bus.c_in = tc;
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub = tsub;
`else
    if (tsub) $display("sub ignored in add-only build");
`endif
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_rel_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_rel_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic tsub, input logic [15:0] es, input logic ec);
    start(ta, tb_, tc, tsub);
    wait_out(tag);
    check({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, es});
    check({tag, "_c_out"}, {31'd0, bus.c_out}, {31'd0, ec});
    release_result(tag);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.out_ready = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum", {16'd0, bus.sum}, 32'd0);
    check("rst_c_out", {31'd0, bus.c_out}, 32'd0);

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("prop", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Result held under backpressure while new operands are offered
    start(16'h00FF, 16'h0000, 1'b1, 1'b0);
    wait_out("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222;
      check("hold_sum", {16'd0, bus.sum}, 32'h0100);
      check("hold_c_out", {31'd0, bus.c_out}, 32'd0);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    release_result("hold");
    @(negedge clk);
    check("hold_idle_sum", {16'd0, bus.sum}, 32'h0100);
    check("hold_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset one cycle into RUN discards the operation
    start(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_sum", {16'd0, bus.sum}, 32'd0);
    check("mid_rst_c_out", {31'd0, bus.c_out}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

    // Back-to-back with out_ready held high
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a = 16'h8000; bus.b = 16'h8000; bus.c_in = 1'b0; bus.in_valid = 1'b1;
    t1 = cyc;
    @(posedge clk); #1;
    bus.a = 16'h7FFF; bus.b = 16'h0001;
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    check("b2b1_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("b2b1_sum", {16'd0, bus.sum}, 32'h0000);
    check("b2b1_c_out", {31'd0, bus.c_out}, 32'd1);
    t2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        t2 = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_accept_spacing", t2 - t1, 6);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    check("b2b2_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("b2b2_sum", {16'd0, bus.sum}, 32'h8000);
    check("b2b2_c_out", {31'd0, bus.c_out}, 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b_done_in_ready", {31'd0, bus.in_ready}, 32'd1);

`ifdef NIBBLE_SERIAL_SUB_EN
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
